// File: rtl/lane_hit_judge.sv
// lane_hit_judge: per-lane timing judge for a falling-block rhythm game.
// Tracks one block per lane, grades the key press as perfect/good/miss,
// drives the renderer hide flag and keeps saturating score/combo counters.
// Optional build macro: LANE_JUDGE_STRAY_PENALTY_EN -- when defined, a key
// press that lands outside the judging window breaks the combo and shows a
// miss grade (no miss pulse); when undefined such presses are ignored.
module lane_hit_judge #(
  parameter int PERF_LO   = 600,
  parameter int PERF_HI   = 620,
  parameter int GOOD_LO   = 580,
  parameter int GOOD_HI   = 640,
  parameter int OFF_H     = 720,
  parameter int PERF_PTS  = 3,
  parameter int GOOD_PTS  = 1,
  parameter int SCORE_MAX = 9999
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        restart,
  input  logic        stop_or_endgame,
  input  logic        key,
  input  logic [9:0]  block_h,
  output logic        hit,
  output logic        miss,
  output logic [1:0]  grade,
  output logic        hide,
  output logic [13:0] score,
  output logic [7:0]  combo,
  output logic [7:0]  max_combo
);

  localparam logic [9:0]  PERF_LO_H = 10'(PERF_LO);
  localparam logic [9:0]  PERF_HI_H = 10'(PERF_HI);
  localparam logic [9:0]  GOOD_LO_H = 10'(GOOD_LO);
  localparam logic [9:0]  GOOD_HI_H = 10'(GOOD_HI);
  localparam logic [9:0]  OFF_H_H   = 10'(OFF_H);
  localparam logic [13:0] PERF_PTS_S  = 14'(PERF_PTS);
  localparam logic [13:0] GOOD_PTS_S  = 14'(GOOD_PTS);
  localparam logic [13:0] SCORE_MAX_S = 14'(SCORE_MAX);

`ifdef LANE_JUDGE_STRAY_PENALTY_EN
  localparam logic STRAY_PEN = 1'b1;
`else
  localparam logic STRAY_PEN = 1'b0;
`endif

  localparam logic [1:0] G_NONE = 2'd0;
  localparam logic [1:0] G_GOOD = 2'd1;
  localparam logic [1:0] G_PERF = 2'd2;
  localparam logic [1:0] G_MISS = 2'd3;

  typedef enum logic [1:0] {EMPTY, FALLING, DONE} state_t;

  state_t      state;
  logic [9:0]  prev_h;
  logic        key_q;

  logic        key_edge, spawn, in_good, in_perf;
  logic        eff_falling, old_miss, hit_c, late_miss, stray, penalty, miss_c, leave_done;
  logic [7:0]  combo_nx, max_nx;
  logic [13:0] score_nx;
  logic [1:0]  grade_nx;
  logic        hide_nx;
  state_t      state_nx;

  // Score add clamped at SCORE_MAX.
  function automatic logic [13:0] sat_score(input logic [13:0] s, input logic [13:0] pts);
    logic [14:0] sum;
    sum = {1'b0, s} + {1'b0, pts};
    if (sum > {1'b0, SCORE_MAX_S}) return SCORE_MAX_S;
    return sum[13:0];
  endfunction

  // Combo increment clamped at 255.
  function automatic logic [7:0] sat_combo(input logic [7:0] c);
    return (c == 8'hFF) ? c : c + 8'd1;
  endfunction

  assign key_edge = key & ~key_q;
  assign spawn    = (block_h < prev_h) || ((prev_h == OFF_H_H) && (block_h != OFF_H_H));
  assign in_good  = (block_h >= GOOD_LO_H) && (block_h <= GOOD_HI_H);
  assign in_perf  = (block_h >= PERF_LO_H) && (block_h <= PERF_HI_H);

  // Judgement for this tick; a spawn makes the new block the one being judged.
  always_comb begin
    eff_falling = spawn || (state == FALLING);
    old_miss    = spawn && (state == FALLING);
    hit_c       = eff_falling && key_edge && in_good;
    late_miss   = eff_falling && !key_edge && (block_h > GOOD_HI_H);
    stray       = key_edge && !hit_c;
    penalty     = stray && STRAY_PEN;
    miss_c      = old_miss || late_miss;
    leave_done  = !spawn && (state == DONE) && (block_h == OFF_H_H);

    state_nx = state;
    if (hit_c || late_miss)  state_nx = DONE;
    else if (eff_falling)    state_nx = FALLING;
    else if (leave_done)     state_nx = EMPTY;

    hide_nx = hide;
    if (hit_c)                    hide_nx = 1'b1;
    else if (spawn || leave_done) hide_nx = 1'b0;

    grade_nx = grade;
    if (hit_c)                  grade_nx = in_perf ? G_PERF : G_GOOD;
    else if (miss_c || penalty) grade_nx = G_MISS;

    combo_nx = (miss_c || penalty) ? 8'd0 : combo;
    score_nx = score;
    if (hit_c) begin
      combo_nx = sat_combo(combo_nx);
      score_nx = sat_score(score, in_perf ? PERF_PTS_S : GOOD_PTS_S);
    end
    max_nx = (combo_nx > max_combo) ? combo_nx : max_combo;
  end

  // Lane FSM and registered outputs; freeze holds all state and blanks pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= EMPTY;  prev_h <= OFF_H_H;  key_q <= 1'b0;
      hit <= 1'b0;  miss <= 1'b0;  grade <= G_NONE;  hide <= 1'b0;
      score <= '0;  combo <= '0;  max_combo <= '0;
    end else if (restart) begin
      state <= EMPTY;  prev_h <= OFF_H_H;  key_q <= 1'b0;
      hit <= 1'b0;  miss <= 1'b0;  grade <= G_NONE;  hide <= 1'b0;
      score <= '0;  combo <= '0;  max_combo <= '0;
    end else if (stop_or_endgame) begin
      hit  <= 1'b0;
      miss <= 1'b0;
    end else begin
      state     <= state_nx;
      prev_h    <= block_h;
      key_q     <= key;
      hit       <= hit_c;
      miss      <= miss_c;
      grade     <= grade_nx;
      hide      <= hide_nx;
      score     <= score_nx;
      combo     <= combo_nx;
      max_combo <= max_nx;
    end
  end

endmodule

// File: tb/tb_lane_hit_judge.sv
// Bench for lane_hit_judge: directed stimulus with hand-computed expected
// pulses queued into a scoreboard and popped by a negedge monitor.
module tb_lane_hit_judge;

  logic        clk = 1'b0;
  logic        rst_n, restart, stop_or_endgame, key;
  logic [9:0]  block_h;
  logic        hit, miss, hide;
  logic [1:0]  grade;
  logic [13:0] score;
  logic [7:0]  combo, max_combo;

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic        hit;
    logic        miss;
    logic [1:0]  grade;
    logic        hide;
    logic [13:0] score;
    logic [7:0]  combo;
    logic [7:0]  maxc;
  } exp_t;

  exp_t q[$];

  lane_hit_judge dut (
    .clk(clk), .rst_n(rst_n), .restart(restart), .stop_or_endgame(stop_or_endgame),
    .key(key), .block_h(block_h), .hit(hit), .miss(miss), .grade(grade),
    .hide(hide), .score(score), .combo(combo), .max_combo(max_combo)
  );

  always #5 clk = ~clk;

  // Scoreboard monitor: every hit/miss pulse must match the next queued entry.
  always @(negedge clk) begin
    if (rst_n && (hit || miss)) begin
      exp_t act, want;
      act = '{hit, miss, grade, hide, score, combo, max_combo};
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_pulse got=%h want=none t=%0t", act, $time);
      end else begin
        want = q.pop_front();
        if (act !== want) begin
          errors++;
          $display("FAIL pulse got=%h want=%h (hit miss grade hide score combo max) t=%0t",
                   act, want, $time);
        end
      end
    end
  end

  task automatic chk(input string name, input int act, input int want);
    checks++;
    if (act != want) begin
      errors++;
      $display("FAIL %s got=%0d want=%0d t=%0t", name, act, want, $time);
    end
  endtask

  task automatic step(input int h, input logic k);
    block_h = 10'(h);
    key = k;
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic h, input logic m, input int g, input logic hd,
                      input int s, input int c, input int mx);
    exp_t e;
    e = '{h, m, 2'(g), hd, 14'(s), 8'(c), 8'(mx)};
    q.push_back(e);
  endtask

  task automatic chk_zero(input string name);
    chk({name, "_grade"}, grade, 0);
    chk({name, "_hide"}, hide, 0);
    chk({name, "_score"}, score, 0);
    chk({name, "_combo"}, combo, 0);
    chk({name, "_max"}, max_combo, 0);
    chk({name, "_pulse"}, {hit, miss}, 0);
  endtask

  initial begin
    rst_n = 1'b0; restart = 1'b0; stop_or_endgame = 1'b0; key = 1'b0; block_h = 10'd720;
    #12;
    chk_zero("reset");
    rst_n = 1'b1;
    step(720, 0); step(720, 0);

    // Perfect hit at 610, hide clears when block leaves.
    step(120, 0); step(300, 0); step(605, 0);
    push(1, 0, 2, 1, 3, 1, 1);
    step(610, 1);
    chk("hide_after_hit", hide, 1);
    step(615, 1); step(650, 1); step(700, 0);
    chk("hide_still_done", hide, 1);
    step(720, 0);
    chk("hide_cleared", hide, 0);

    // Good hit at 585, then late press at 641 -> miss.
    step(120, 0);
    push(1, 0, 1, 1, 4, 2, 2);
    step(585, 1);
    step(720, 0);
    step(100, 0); step(600, 0);
    step(641, 1);
    chk("no_hit_641", hit, 0);
    push(0, 1, 3, 0, 4, 0, 2);
    step(642, 1);
    step(720, 0);

    // Restart, then ten perfects and a miss.
    restart = 1'b1;
    step(720, 0);
    restart = 1'b0;
    chk_zero("restart");
    for (int i = 1; i <= 10; i++) begin
      step(120, 0);
      push(1, 0, 2, 1, 3 * i, i, i);
      step(610, 1);
      step(720, 0);
    end
    step(120, 0);
    push(0, 1, 3, 0, 30, 0, 10);
    step(650, 0);
    step(720, 0);
    chk("max_after_miss", max_combo, 10);

    // Respawn over unjudged block -> miss; held key judged only once.
    step(120, 0); step(500, 0);
    push(0, 1, 3, 0, 30, 0, 10);
    step(120, 0);
    push(1, 0, 2, 1, 33, 1, 10);
    step(610, 1);
    step(720, 1); step(120, 1); step(610, 1);
    push(0, 1, 3, 0, 33, 0, 10);
    step(650, 1);
    step(720, 0);

    // Freeze: edge during stop is not judged; resumes after release.
    step(120, 0); step(605, 0);
    stop_or_endgame = 1'b1;
    step(610, 1); step(612, 1);
    chk("frozen_score", score, 33);
    chk("frozen_grade", grade, 3);
    chk("frozen_hide", hide, 0);
    stop_or_endgame = 1'b0;
    push(1, 0, 2, 1, 36, 1, 10);
    step(612, 1);
    step(720, 0);

    // Stray press at 300.
    step(120, 0);
    step(300, 1);
`ifdef LANE_JUDGE_STRAY_PENALTY_EN
    chk("stray_combo", combo, 0);
    chk("stray_grade", grade, 3);
    step(300, 0);
    push(1, 0, 2, 1, 39, 1, 10);
`else
    chk("stray_combo", combo, 1);
    chk("stray_grade", grade, 2);
    step(300, 0);
    push(1, 0, 2, 1, 39, 2, 10);
`endif
    step(610, 1);
    step(720, 0);

    // Asynchronous reset mid-fall discards the block without a miss.
    step(120, 0); step(500, 0);
    #2;
    rst_n = 1'b0;
    block_h = 10'd720;
    key = 1'b0;
    #2;
    chk_zero("midfall_reset");
    rst_n = 1'b1;
    step(720, 0); step(720, 0);

    // Saturation of score (9999) and combo (255).
    for (int i = 1; i <= 3334; i++) begin
      int s, c;
      s = (3 * i > 9999) ? 9999 : 3 * i;
      c = (i > 255) ? 255 : i;
      push(1, 0, 2, 1, s, c, c);
      step(610, 1);
      step(720, 0);
    end
    chk("score_sat", score, 9999);
    chk("combo_sat", combo, 255);

    step(720, 0); step(720, 0); step(720, 0);
    chk("queue_drained", q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
